// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and helpers for the frequency-meter sequencer.
//   state_t  - measurement sequencer states
//   range_t  - 2-bit gate range (0 = 1 s, 1 = 100 ms, 2 = 10 ms)
//   gate_len - gate length in clock cycles for a given clock rate and range
package freq_meter_pkg;

   typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, EVAL} state_t;

   typedef logic [1:0] range_t;

   localparam range_t RNG_1S    = 2'd0;
   localparam range_t RNG_100MS = 2'd1;
   localparam range_t RNG_10MS  = 2'd2;

   // Any range code above 2 falls into the shortest gate.
   function automatic int unsigned gate_len(input int unsigned clk_hz, input range_t rng);
      case (rng)
         RNG_1S:    return clk_hz;
         RNG_100MS: return clk_hz / 10;
         default:   return clk_hz / 100;
      endcase
   endfunction

endpackage

// File: rtl/freq_gate_ctrl_gate_timer.sv
// gate_timer: loadable down-counter that saturates at zero.
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_load      - load i_load_val (wins over i_en)
//   i_en        - decrement by one while nonzero
//   i_load_val  - value to load
//   o_done      - counter is zero
module gate_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic         i_en,
   input  logic [W-1:0] i_load_val,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    r_cnt <= '0;
      else if (i_load)               r_cnt <= i_load_val;
      else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: measurement sequencer for the frequency-meter datapath.
// Clears and gates an external edge counter over timed windows, then
// publishes the count with its range tag. Range is manual or auto-ranged.
//   clk, rst_n     - clock, asynchronous active-low reset
//   run            - measure continuously while high
//   range_auto     - 1 = auto-range, 0 = manual (range_sel)
//   range_sel      - manual range, 3 behaves as 2
//   cnt_value      - external edge count
//   cnt_ovf        - sticky counter overflow
//   cnt_clr        - one-cycle counter clear
//   cnt_en         - counter gate
//   result         - last published count
//   result_range   - range used for result
//   result_valid   - one-cycle publish strobe
//   over_range     - overflow captured with result
//   busy           - sequencer not idle
module freq_gate_ctrl
   import freq_meter_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int CNT_W    = 10,
   parameter int SYNC_LAT = 2,
   parameter int LOW_TH   = 100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             range_auto,
   input  logic [1:0]       range_sel,
   input  logic [CNT_W-1:0] cnt_value,
   input  logic             cnt_ovf,
   output logic             cnt_clr,
   output logic             cnt_en,
   output logic [CNT_W-1:0] result,
   output logic [1:0]       result_range,
   output logic             result_valid,
   output logic             over_range,
   output logic             busy
);

   localparam int GW = $clog2(CLK_HZ + 1);

   state_t           r_state, w_nxt;
   range_t           r_range, w_clr_range, w_eval_range;
   logic             r_auto;
   logic             w_done, w_load, w_tmr_en;
   logic [GW-1:0]    w_load_val;
   logic             r_cnt_clr, r_cnt_en, r_valid, r_over, r_busy;
   logic [CNT_W-1:0] r_result;
   range_t           r_result_range;

   // Mode and manual range are sampled only in CLEAR, so mid-measurement
   // changes wait for the next measurement.
   always_comb begin
      w_clr_range = r_range;
      if (!range_auto) w_clr_range = (range_sel > RNG_10MS) ? RNG_10MS : range_sel;
   end

   // Overflow blocks a down-step even when it cannot step up (range 2).
   always_comb begin
      w_eval_range = r_range;
      if (cnt_ovf && r_range < RNG_10MS)
         w_eval_range = r_range + 2'd1;
      else if (!cnt_ovf && cnt_value < CNT_W'(LOW_TH) && r_range > RNG_1S)
         w_eval_range = r_range - 2'd1;
   end

   // One timer serves both the gate window and the settle window.
   assign w_load     = (r_state == CLEAR) || (r_state == GATE && w_done);
   assign w_tmr_en   = (r_state == GATE) || (r_state == SETTLE);
   assign w_load_val = (r_state == CLEAR) ? GW'(gate_len(CLK_HZ, w_clr_range) - 1)
                                          : GW'(SYNC_LAT - 1);

   gate_timer #(.W(GW)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_en       (w_tmr_en),
      .i_load_val (w_load_val),
      .o_done     (w_done)
   );

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    if (run) w_nxt = CLEAR;
         CLEAR:   w_nxt = run ? GATE : IDLE;
         GATE:    if (!run) w_nxt = IDLE; else if (w_done) w_nxt = SETTLE;
         SETTLE:  if (!run) w_nxt = IDLE; else if (w_done) w_nxt = EVAL;
         EVAL:    w_nxt = run ? CLEAR : IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state they belong to; EVAL capture happens on the edge into EVAL so the
   // published word and its strobe appear together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_range        <= RNG_1S;
         r_auto         <= 1'b0;
         r_cnt_clr      <= 1'b0;
         r_cnt_en       <= 1'b0;
         r_valid        <= 1'b0;
         r_busy         <= 1'b0;
         r_over         <= 1'b0;
         r_result       <= '0;
         r_result_range <= RNG_1S;
      end else begin
         r_state   <= w_nxt;
         r_cnt_clr <= (w_nxt == CLEAR);
         r_cnt_en  <= (w_nxt == GATE);
         r_valid   <= (w_nxt == EVAL);
         r_busy    <= (w_nxt != IDLE);
         if (r_state == CLEAR) begin
            r_range <= w_clr_range;
            r_auto  <= range_auto;
         end
         if (w_nxt == EVAL) begin
            r_result       <= cnt_value;
            r_result_range <= r_range;
            r_over         <= cnt_ovf;
            if (r_auto) r_range <= w_eval_range;
         end
      end
   end

   assign cnt_clr      = r_cnt_clr;
   assign cnt_en       = r_cnt_en;
   assign result       = r_result;
   assign result_range = r_result_range;
   assign result_valid = r_valid;
   assign over_range   = r_over;
   assign busy         = r_busy;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
module tb_freq_gate_ctrl;

   localparam int CLK_HZ   = 1000;
   localparam int CNT_W    = 10;
   localparam int SYNC_LAT = 2;
   localparam int LOW_TH   = 100;

   logic             clk = 1'b0, rst_n = 1'b0, run = 1'b0, range_auto = 1'b0;
   logic [1:0]       range_sel = 2'd0;
   logic [CNT_W-1:0] cnt_value;
   logic             cnt_ovf;
   logic             cnt_clr, cnt_en, result_valid, over_range, busy;
   logic [CNT_W-1:0] result;
   logic [1:0]       result_range;

   int errors = 0, checks = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   freq_gate_ctrl #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .SYNC_LAT(SYNC_LAT), .LOW_TH(LOW_TH)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .range_auto(range_auto), .range_sel(range_sel),
      .cnt_value(cnt_value), .cnt_ovf(cnt_ovf), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
      .result(result), .result_range(result_range), .result_valid(result_valid),
      .over_range(over_range), .busy(busy)
   );

   // External counter model: counts up to m_edges edges while gated.
   logic [CNT_W-1:0] m_cnt = '0;
   logic             m_ovf = 1'b0;
   int               m_edges = 0;
   bit               m_ovf_mode = 1'b0;

   always @(posedge clk) begin
      if (cnt_clr) begin
         m_cnt <= '0;
         m_ovf <= 1'b0;
      end else if (cnt_en) begin
         if (int'(m_cnt) < m_edges) m_cnt <= m_cnt + 1'b1;
         if (m_ovf_mode) m_ovf <= 1'b1;
      end
   end
   assign cnt_value = m_cnt;
   assign cnt_ovf   = m_ovf;

   // Scoreboard of expected publishes.
   typedef struct {int res; int rng; int ovr; int glen;} exp_t;
   exp_t sb[$];
   exp_t e;

   int en_len = 0, clr_w = 0, v_cyc = 0, prev_v_cyc = 0, n_valid = 0;
   bit prev_clr = 1'b0, both_seen = 1'b0;

   always @(negedge clk) begin
      if (cnt_clr) begin
         clr_w  = prev_clr ? clr_w + 1 : 1;
         en_len = 0;
      end
      prev_clr = cnt_clr;
      if (cnt_en) en_len++;
      if (cnt_clr && cnt_en) both_seen = 1'b1;
      if (result_valid) begin
         prev_v_cyc = v_cyc;
         v_cyc      = cyc;
         n_valid++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid at cycle %0d result=%0d", cyc, result);
         end else begin
            e = sb.pop_front();
            if (result !== CNT_W'(e.res)) begin errors++;
               $display("FAIL result got=%0d exp=%0d", result, e.res); end
            checks++;
            if (result_range !== 2'(e.rng)) begin errors++;
               $display("FAIL result_range got=%0d exp=%0d", result_range, e.rng); end
            checks++;
            if (over_range !== 1'(e.ovr)) begin errors++;
               $display("FAIL over_range got=%0b exp=%0d", over_range, e.ovr); end
            checks++;
            if (en_len != e.glen) begin errors++;
               $display("FAIL gate_len got=%0d exp=%0d", en_len, e.glen); end
            checks++;
            if (clr_w != 1) begin errors++;
               $display("FAIL clr_pulse_width got=%0d exp=1", clr_w); end
            checks++;
            if (both_seen) begin errors++;
               $display("FAIL clr_en_overlap got=1 exp=0"); end
         end
      end
   end

   task automatic push_meas(input int edges, input bit ovf, input int rng, input int glen);
      m_edges    = edges;
      m_ovf_mode = ovf;
      sb.push_back('{edges, rng, int'(ovf), glen});
   endtask

   task automatic wait_valid(input int budget, input string nm);
      int n0 = n_valid;
      int k  = 0;
      while (n_valid == n0 && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      checks++;
      if (n_valid == n0) begin errors++;
         $display("FAIL %s_timeout got=no_valid exp=valid within %0d cycles", nm, budget); end
   endtask

   task automatic wait_en(input int budget, input string nm);
      int k = 0;
      while (!cnt_en && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      checks++;
      if (!cnt_en) begin errors++;
         $display("FAIL %s_timeout got=cnt_en_low exp=cnt_en_high", nm); end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (cnt_clr !== 1'b0)      begin errors++; $display("FAIL rst_cnt_clr got=%b exp=0", cnt_clr); end
      checks++; if (cnt_en !== 1'b0)       begin errors++; $display("FAIL rst_cnt_en got=%b exp=0", cnt_en); end
      checks++; if (result !== '0)         begin errors++; $display("FAIL rst_result got=%0d exp=0", result); end
      checks++; if (result_range !== 2'd0) begin errors++; $display("FAIL rst_range got=%0d exp=0", result_range); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", result_valid); end
      checks++; if (over_range !== 1'b0)   begin errors++; $display("FAIL rst_over got=%b exp=0", over_range); end
      checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      rst_n = 1'b1;
   endtask

   task automatic test_manual;
      int c0;
      range_auto = 1'b0;
      range_sel  = 2'd1;
      push_meas(37, 1'b0, 1, 100);
      c0  = cyc;
      run = 1'b1;
      wait_valid(300, "manual_first");
      checks++;
      if (v_cyc - c0 != 104) begin errors++;
         $display("FAIL first_latency got=%0d exp=104", v_cyc - c0); end
      push_meas(37, 1'b0, 1, 100);
      wait_valid(300, "manual_second");
      checks++;
      if (v_cyc - prev_v_cyc != 104) begin errors++;
         $display("FAIL period got=%0d exp=104", v_cyc - prev_v_cyc); end
      run = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_auto_up;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      rst_n      = 1'b1;
      range_auto = 1'b1;
      push_meas(7, 1'b1, 0, 1000);
      run = 1'b1;
      wait_valid(1100, "auto_up0");
      push_meas(7, 1'b1, 1, 100);  wait_valid(200, "auto_up1");
      push_meas(7, 1'b1, 2, 10);   wait_valid(100, "auto_up2");
      push_meas(7, 1'b1, 2, 10);   wait_valid(100, "auto_up3");
      run = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic test_auto_down;
      range_auto = 1'b1;
      push_meas(5, 1'b0, 2, 10);
      run = 1'b1;
      wait_valid(100, "auto_dn0");
      push_meas(5, 1'b0, 1, 100);    wait_valid(200, "auto_dn1");
      push_meas(5, 1'b0, 0, 1000);   wait_valid(1100, "auto_dn2");
      push_meas(5, 1'b0, 0, 1000);   wait_valid(1100, "auto_dn3");
      push_meas(100, 1'b1, 0, 1000); wait_valid(1100, "auto_ovf0");
      push_meas(100, 1'b0, 1, 100);  wait_valid(200, "auto_th0");
      push_meas(100, 1'b0, 1, 100);  wait_valid(200, "auto_th1");
      run = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic test_abort;
      int n0;
      range_auto = 1'b0;
      range_sel  = 2'd1;
      m_edges    = 10;
      m_ovf_mode = 1'b0;
      n0  = n_valid;
      run = 1'b1;
      wait_en(50, "abort_gate");
      repeat (49) @(negedge clk);
      #1;
      run = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL abort_cnt_en got=%b exp=0", cnt_en); end
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
      repeat (150) @(negedge clk);
      #1;
      checks++; if (n_valid != n0)        begin errors++; $display("FAIL abort_valid got=%0d exp=%0d", n_valid, n0); end
      checks++; if (result !== 10'd100)   begin errors++; $display("FAIL abort_result got=%0d exp=100", result); end
      checks++; if (result_range !== 2'd1) begin errors++; $display("FAIL abort_range got=%0d exp=1", result_range); end
      checks++; if (over_range !== 1'b0)  begin errors++; $display("FAIL abort_over got=%b exp=0", over_range); end
   endtask

   task automatic test_reset_mid;
      range_auto = 1'b0;
      range_sel  = 2'd1;
      m_edges    = 10;
      run        = 1'b1;
      wait_en(50, "rstmid_gate");
      repeat (20) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      run   = 1'b0;
      #1;
      checks++; if (cnt_en !== 1'b0)       begin errors++; $display("FAIL rstmid_cnt_en got=%b exp=0", cnt_en); end
      checks++; if (cnt_clr !== 1'b0)      begin errors++; $display("FAIL rstmid_cnt_clr got=%b exp=0", cnt_clr); end
      checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      checks++; if (result !== '0)         begin errors++; $display("FAIL rstmid_result got=%0d exp=0", result); end
      checks++; if (result_range !== 2'd0) begin errors++; $display("FAIL rstmid_range got=%0d exp=0", result_range); end
      checks++; if (over_range !== 1'b0)   begin errors++; $display("FAIL rstmid_over got=%b exp=0", over_range); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", result_valid); end
      @(negedge clk);
      #1;
      rst_n      = 1'b1;
      range_auto = 1'b1;   // auto keeps the reset range, exposing it as the gate length
      push_meas(150, 1'b0, 0, 1000);
      run = 1'b1;
      wait_valid(1100, "rstmid_restart");
      run = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic test_range_sel;
      range_auto = 1'b0;
      range_sel  = 2'd0;
      push_meas(20, 1'b0, 0, 1000);
      run = 1'b1;
      wait_en(50, "rsel_gate");
      repeat (10) @(negedge clk);
      #1;
      range_sel = 2'd2;
      wait_valid(1100, "rsel_cur");
      push_meas(4, 1'b0, 2, 10);
      wait_valid(100, "rsel_next");
      range_sel = 2'd3;
      push_meas(4, 1'b0, 2, 10);
      wait_valid(100, "rsel_three");
      run = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   initial begin
      test_reset;
      test_manual;
      test_auto_up;
      test_auto_down;
      test_abort;
      test_reset_mid;
      test_range_sel;
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin errors++;
         $display("FAIL scoreboard_drain got=%0d exp=0 pending", sb.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
